// File: rtl/text_cursor_pkg.sv
// Shared types and constants for the UART-to-VGA text cursor controller.
package text_cursor_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor_ctrl_sweep.sv
// Row-major cell counter that drives the full-screen clear sweep.
module clear_sweep_counter #(
  parameter int  ROWS  = 4,
  parameter int  COLS  = 32,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             done
);
  import text_cursor_pkg::*;

  logic [ROW_W+COL_W-1:0] cnt_q, cnt_d;

  // Natural wrap of the power-of-two counter lets a back-to-back sweep restart at cell 0.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign {row, col} = cnt_q;
  assign done       = run && (&cnt_q);

endmodule

// File: rtl/text_cursor_ctrl.sv
// Cursor and RAM-write sequencer for the UART text terminal.
// Optional feature: define TEXT_CURSOR_BACKSPACE_EN to make 0x08 erase the previous cell.
module text_cursor_ctrl #(
  parameter int         COLS  = 32,
  parameter int         ROWS  = 4,
  parameter logic [7:0] BLANK = 8'h20,
  localparam int        COL_W = $clog2(COLS),
  localparam int        ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             clear_req,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy
);
  import text_cursor_pkg::*;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic             last_cr_q, last_cr_d;
  logic             clear_pending_q, clear_pending_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             sweep_start;
  logic             sweep_run;
  logic [ROW_W-1:0] sweep_row;
  logic [COL_W-1:0] sweep_col;
  logic             sweep_done;

  assign rx_ready    = (state_q == ST_IDLE) && !clear_pending_q && !clear_req;
  assign accept      = rx_valid && rx_ready;
  assign sweep_start = (state_q == ST_IDLE);
  assign sweep_run   = (state_q == ST_CLEAR);

  clear_sweep_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (sweep_start),
    .run   (sweep_run),
    .row   (sweep_row),
    .col   (sweep_col),
    .done  (sweep_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A form-feed byte is treated exactly like a clear request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req || (accept && (rx_data == ASCII_FF))) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (sweep_done && !clear_pending_q && !clear_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_row_d       = cur_row_q;
    cur_col_d       = cur_col_q;
    last_cr_d       = last_cr_q;
    clear_pending_d = clear_pending_q;
    wr_en_d         = 1'b0;
    wr_row_d        = wr_row_q;
    wr_col_d        = wr_col_q;
    wr_data_d       = wr_data_q;
    busy_d          = (state_q == ST_CLEAR);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_cr_d = 1'b0;
          if (is_printable(rx_data)) begin
            wr_en_d   = 1'b1;
            wr_row_d  = cur_row_q;
            wr_col_d  = cur_col_q;
            wr_data_d = rx_data;
            cur_col_d = cur_col_q + 1'b1;
            if (&cur_col_q) begin
              cur_row_d = cur_row_q + 1'b1;
            end
          end else if (rx_data == ASCII_CR) begin
            cur_col_d = '0;
            cur_row_d = cur_row_q + 1'b1;
            last_cr_d = 1'b1;
          end else if (rx_data == ASCII_LF) begin
            // LF right after CR completes a CRLF pair and must not add a second line.
            if (!last_cr_q) begin
              cur_col_d = '0;
              cur_row_d = cur_row_q + 1'b1;
            end
`ifdef TEXT_CURSOR_BACKSPACE_EN
          end else if (rx_data == ASCII_BS) begin
            if ((cur_row_q != '0) || (cur_col_q != '0)) begin
              cur_col_d = cur_col_q - 1'b1;
              if (cur_col_q == '0) begin
                cur_row_d = cur_row_q - 1'b1;
              end
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_d;
              wr_col_d  = cur_col_d;
              wr_data_d = BLANK;
            end
`endif
          end
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = sweep_row;
        wr_col_d  = sweep_col;
        wr_data_d = BLANK;
        if (clear_req) begin
          clear_pending_d = 1'b1;
        end
        // On the last cell either restart for a queued request or home the cursor.
        if (sweep_done) begin
          if (clear_pending_q || clear_req) begin
            clear_pending_d = 1'b0;
          end else begin
            cur_row_d = '0;
            cur_col_d = '0;
            last_cr_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_row_q       <= '0;
      cur_col_q       <= '0;
      last_cr_q       <= 1'b0;
      clear_pending_q <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_row_q        <= '0;
      wr_col_q        <= '0;
      wr_data_q       <= '0;
      busy_q          <= 1'b0;
    end else begin
      cur_row_q       <= cur_row_d;
      cur_col_q       <= cur_col_d;
      last_cr_q       <= last_cr_d;
      clear_pending_q <= clear_pending_d;
      wr_en_q         <= wr_en_d;
      wr_row_q        <= wr_row_d;
      wr_col_q        <= wr_col_d;
      wr_data_q       <= wr_data_d;
      busy_q          <= busy_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_row  = wr_row_q;
  assign wr_col  = wr_col_q;
  assign wr_data = wr_data_q;
  assign cur_row = cur_row_q;
  assign cur_col = cur_col_q;
  assign busy    = busy_q;

endmodule
